led_index_gen: RTL

- Upstream stage of the 3-to-8 one-hot decoder. Generates the 3-bit select code that drives the decoder's in_1/in_2/in_3 inputs.
- Two raw push-buttons, both active-low:
  - key_step: advances the code by one in manual mode.
  - key_mode: toggles between manual mode and auto-run mode.
- In auto-run, the code advances every STEP_CNT clocks.

---
 rtl/led_pkg.sv | 20 ++
 rtl/led_index_gen_key_filter.sv | 61 ++++++
 rtl/led_index_gen.sv | 88 ++++++++
 3 files changed

// File: rtl/led_pkg.sv
`default_nettype none
// ============================================================================
// Module      : led_pkg
// Description : Shared widths and default timing constants for the LED
//               index generator (decoder select-code front end).
// Revision    : 1.0 - initial release
// ============================================================================
package led_pkg;

  // Index width: one bit per decoder select input (in_1/in_2/in_3).
  localparam int IDX_W = 3;

  // Debounce length: 20 ms at 50 MHz.
  localparam logic [19:0] CNT_MAX_DEF = 20'd999_999;

  // Auto-run step period: 1 s at 50 MHz.
  localparam logic [25:0] STEP_CNT_DEF = 26'd49_999_999;

endpackage : led_pkg
`default_nettype wire

// File: rtl/led_index_gen_key_filter.sv
`default_nettype none
// ============================================================================
// Module      : key_filter
// Description : Active-low push-button conditioner. Two-flop synchronizer,
//               saturating debounce counter and a single registered press
//               pulse per stable press.
// Revision    : 1.0 - initial release
// ============================================================================
module key_filter
  import led_pkg::*;
#(
  parameter logic [19:0] CNT_MAX = CNT_MAX_DEF
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic key_in,
  output logic press
);

  localparam logic [19:0] CNT_TOP  = CNT_MAX - 20'd1;
  localparam logic [19:0] CNT_FIRE = CNT_MAX - 20'd2;

  logic        key_s1;
  logic        key_s2;
  logic [1:0]  fill;
  logic        armed;
  logic [19:0] cnt;

  // Synchronize the raw key, debounce it and emit one pulse per press.
  // The synchronizer resets to "released", so for two cycles after reset
  // it shows its reset value rather than the real key. 'fill' marks when
  // genuine samples have reached key_s2; the filter only arms once it has
  // seen a genuinely released key, so a key held through reset must be
  // released and pressed again before it counts.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      key_s1 <= 1'b1;
      key_s2 <= 1'b1;
      fill   <= 2'b00;
      armed  <= 1'b0;
      cnt    <= 20'd0;
      press  <= 1'b0;
    end else begin
      key_s1 <= key_in;
      key_s2 <= key_s1;
      fill   <= {fill[0], 1'b1};
      if (fill[1] && key_s2) begin
        armed <= 1'b1;
      end
      if (key_s2 || !armed) begin
        cnt <= 20'd0;
      end else if (cnt < CNT_TOP) begin
        cnt <= cnt + 20'd1;
      end
      // cnt passes CNT_FIRE only once per low period, so this fires once.
      press <= armed && !key_s2 && (cnt == CNT_FIRE);
    end
  end

endmodule : key_filter
`default_nettype wire

// File: rtl/led_index_gen.sv
`default_nettype none
// ============================================================================
// Module      : led_index_gen
// Description : Generates the 3-bit select code for the 3-to-8 one-hot
//               decoder. Manual stepping via key_step, auto-run toggled
//               via key_mode; in auto-run the code advances every
//               STEP_CNT clocks.
// Revision    : 1.0 - initial release
// ============================================================================
module led_index_gen
  import led_pkg::*;
#(
  parameter logic [19:0] CNT_MAX  = CNT_MAX_DEF,
  parameter logic [25:0] STEP_CNT = STEP_CNT_DEF
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic key_step,
  input  logic key_mode,
  output logic out_1,
  output logic out_2,
  output logic out_3,
  output logic run_mode,
  output logic idx_chg
);

  localparam logic [25:0] PRE_TOP = STEP_CNT - 26'd1;

  logic             step_press;
  logic             mode_press;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] idx_nxt;
  logic [25:0]      pre;
  logic [25:0]      pre_nxt;
  logic             run_nxt;
  logic             adv;

  key_filter #(.CNT_MAX(CNT_MAX)) u_step_filter (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .key_in  (key_step),
    .press   (step_press)
  );

  key_filter #(.CNT_MAX(CNT_MAX)) u_mode_filter (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .key_in  (key_mode),
    .press   (mode_press)
  );

  // Next-state: advance source depends on the pre-edge run_mode, so a
  // simultaneous step+mode press from manual both steps and enters run.
  always_comb begin
    adv     = 1'b0;
    pre_nxt = pre;
    run_nxt = run_mode ^ mode_press;
    if (run_mode) begin
      adv     = (pre == PRE_TOP);
      pre_nxt = (pre == PRE_TOP) ? 26'd0 : pre + 26'd1;
    end else begin
      adv = step_press;
      if (mode_press) begin
        pre_nxt = 26'd0;
      end
    end
    idx_nxt = idx + {{(IDX_W-1){1'b0}}, adv};
  end

  // State registers; idx_chg is registered together with idx.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      idx      <= '0;
      pre      <= 26'd0;
      run_mode <= 1'b0;
      idx_chg  <= 1'b0;
    end else begin
      idx      <= idx_nxt;
      pre      <= pre_nxt;
      run_mode <= run_nxt;
      idx_chg  <= (idx_nxt != idx);
    end
  end

  assign {out_1, out_2, out_3} = idx;

endmodule : led_index_gen
`default_nettype wire
